// File: rtl/ospreyudp_pkg.sv
// Shared types and constants for the ospreyUDP transmit path.
// Optional statistics counters are enabled with the OSPREYUDP_TX_STATS_EN macro.
package ospreyudp_pkg;

    // Header-insert sequencer states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR0    = 2'd1,
        HDR1    = 2'd2,
        PAYLOAD = 2'd3
    } state_e;

    // UDP framing limits
    localparam int UDP_HDR_BYTES   = 8;
    localparam int UDP_MAX_PAYLOAD = 65527;

    // Register slave word indices feeding the cfg_* inputs
    localparam int REG_SRC  = 0;
    localparam int REG_DST  = 1;
    localparam int REG_LEN  = 2;
    localparam int REG_CTRL = 3;

endpackage

// File: rtl/ospreyudp_popcount4.sv
// Byte count of a 4-bit AXI-Stream keep field (0..4), purely combinational.
module ospreyudp_popcount4 (
    input  logic [3:0] keep_i,
    output logic [2:0] count_o
);

    assign count_o = {2'b00, keep_i[0]} + {2'b00, keep_i[1]}
                   + {2'b00, keep_i[2]} + {2'b00, keep_i[3]};

endmodule

// File: rtl/ospreyudp_tx_header_insert.sv
// Prepends the 8-byte UDP header to a 32-bit payload stream and checks the
// delivered payload length against the configured length.
// Define OSPREYUDP_TX_STATS_EN to add the pkt_count/err_count outputs.
module ospreyudp_tx_header_insert
    import ospreyudp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int KEEP_W = DATA_W / 8
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [15:0]       cfg_src_port,
    input  logic [15:0]       cfg_dst_port,
    input  logic [15:0]       cfg_payload_bytes,
    input  logic              cfg_enable,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              len_err,
    output logic              busy
`ifdef OSPREYUDP_TX_STATS_EN
    ,
    output logic [31:0]       pkt_count,
    output logic [15:0]       err_count
`endif
);

    state_e              state_q;
    logic [15:0]         src_q;
    logic [15:0]         dst_q;
    logic [15:0]         len_q;
    logic [15:0]         udp_len_q;
    logic [DATA_W-1:0]   hdr_data_q;
    logic                hdr_valid_q;
    logic [16:0]         byte_cnt_q;
    logic [16:0]         byte_cnt_d;
    logic                len_err_q;
    logic [2:0]          beat_bytes;
    logic                pay_active;
    logic                pay_hs;
    logic                pay_last_hs;

    ospreyudp_popcount4 u_popcount (
        .keep_i  (s_axis_tkeep),
        .count_o (beat_bytes)
    );

    // Payload phase is a straight combinational pass-through; headers come from registers
    assign pay_active    = (state_q == PAYLOAD);
    assign pay_hs        = pay_active && s_axis_tvalid && m_axis_tready;
    assign pay_last_hs   = pay_hs && s_axis_tlast;
    assign byte_cnt_d    = byte_cnt_q + {14'd0, beat_bytes};

    assign s_axis_tready = pay_active && m_axis_tready;
    assign m_axis_tvalid = pay_active ? s_axis_tvalid : hdr_valid_q;
    assign m_axis_tdata  = pay_active ? s_axis_tdata  : hdr_data_q;
    assign m_axis_tkeep  = pay_active ? s_axis_tkeep  : {KEEP_W{hdr_valid_q}};
    assign m_axis_tlast  = pay_active && s_axis_tlast;
    assign len_err       = len_err_q;
    assign busy          = (state_q != IDLE);

    // Sequencer: shadow config capture, header beats, payload byte count and length check
    // NOTE: every register here uses <= so all updates see the pre-edge values together.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            udp_len_q   <= '0;
            hdr_data_q  <= '0;
            hdr_valid_q <= 1'b0;
            byte_cnt_q  <= '0;
            len_err_q   <= 1'b0;
        end else begin
            len_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    hdr_valid_q <= 1'b0;
                    hdr_data_q  <= '0;
                    if (cfg_enable && s_axis_tvalid) begin
                        src_q       <= cfg_src_port;
                        dst_q       <= cfg_dst_port;
                        len_q       <= cfg_payload_bytes;
                        udp_len_q   <= cfg_payload_bytes + 16'(UDP_HDR_BYTES);
                        hdr_data_q  <= {cfg_src_port, cfg_dst_port};
                        hdr_valid_q <= 1'b1;
                        state_q     <= HDR0;
                    end
                end
                HDR0: begin
                    if (m_axis_tready) begin
                        hdr_data_q <= {udp_len_q, 16'h0000};
                        state_q    <= HDR1;
                    end
                end
                HDR1: begin
                    if (m_axis_tready) begin
                        hdr_valid_q <= 1'b0;
                        hdr_data_q  <= '0;
                        state_q     <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (pay_last_hs) begin
                        len_err_q  <= (byte_cnt_d != {1'b0, len_q}) ||
                                      (len_q > 16'(UDP_MAX_PAYLOAD));
                        byte_cnt_q <= '0;
                        state_q    <= IDLE;
                    end else if (pay_hs) begin
                        byte_cnt_q <= byte_cnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef OSPREYUDP_TX_STATS_EN
    logic [31:0] pkt_count_q;
    logic [15:0] err_count_q;

    // Packet counter wraps; error counter saturates
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            pkt_count_q <= '0;
            err_count_q <= '0;
        end else begin
            if (pay_last_hs) begin
                pkt_count_q <= pkt_count_q + 32'd1;
            end
            if (len_err_q && (err_count_q != 16'hFFFF)) begin
                err_count_q <= err_count_q + 16'd1;
            end
        end
    end

    assign pkt_count = pkt_count_q;
    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_ospreyudp_tx_header_insert.sv
// Directed self-checking bench for ospreyudp_tx_header_insert.
// Define OSPREYUDP_TX_STATS_EN to also check the statistics counters.
module tb_ospreyudp_tx_header_insert;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [15:0] cfg_src_port = 16'h1234;
    logic [15:0] cfg_dst_port = 16'h5678;
    logic [15:0] cfg_payload_bytes = 16'd8;
    logic        cfg_enable = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic [3:0]  s_axis_tkeep = '0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        len_err;
    logic        busy;
`ifdef OSPREYUDP_TX_STATS_EN
    logic [31:0] pkt_count;
    logic [15:0] err_count;
`endif

    ospreyudp_tx_header_insert dut (
        .ACLK              (ACLK),
        .ARESET            (ARESET),
        .cfg_src_port      (cfg_src_port),
        .cfg_dst_port      (cfg_dst_port),
        .cfg_payload_bytes (cfg_payload_bytes),
        .cfg_enable        (cfg_enable),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tkeep      (s_axis_tkeep),
        .s_axis_tlast      (s_axis_tlast),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tkeep      (m_axis_tkeep),
        .m_axis_tlast      (m_axis_tlast),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .len_err           (len_err),
        .busy              (busy)
`ifdef OSPREYUDP_TX_STATS_EN
        ,
        .pkt_count         (pkt_count),
        .err_count         (err_count)
`endif
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Output monitor: records every datagram handshake, len_err cycles and stall violations
    logic [36:0] out_q[$];
    int          err_pulses = 0;
    int          stall_viol = 0;
    bit          stalled = 1'b0;
    logic [36:0] stall_word;

    always @(negedge ACLK) begin
        if (ARESET) begin
            stalled = 1'b0;
        end else begin
            if (stalled && !(m_axis_tvalid && ({m_axis_tdata, m_axis_tkeep, m_axis_tlast} == stall_word)))
                stall_viol++;
            if (m_axis_tvalid && m_axis_tready) begin
                out_q.push_back({m_axis_tdata, m_axis_tkeep, m_axis_tlast});
                stalled = 1'b0;
            end else if (m_axis_tvalid) begin
                stalled    = 1'b1;
                stall_word = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
            end else begin
                stalled = 1'b0;
            end
            if (len_err) err_pulses++;
        end
    end

    int pkt_tag = 1;

    function automatic logic [31:0] pdata(input int tag, input int i);
        return 32'hC0DE_0000 | 32'((tag & 8'hFF) << 8) | 32'(i & 8'hFF);
    endfunction

    // Offer nbeats payload beats, holding each until accepted
    task automatic drive_pkt(input int nbeats, input logic [3:0] last_keep, input bit toggle);
        int i = 0;
        int guard = 0;
        bit acc;
        while (i < nbeats && guard < 200) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = pdata(pkt_tag, i);
            s_axis_tkeep  = (i == nbeats - 1) ? last_keep : 4'hF;
            s_axis_tlast  = (i == nbeats - 1);
            m_axis_tready = toggle ? ~m_axis_tready : 1'b1;
            @(negedge ACLK);
            acc = s_axis_tvalid && s_axis_tready;
            @(posedge ACLK);
            #1;
            if (acc) i++;
            guard++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        check("drive beats accepted", 64'(i), 64'(nbeats));
    endtask

    // Compare the captured datagram against the hand-built expectation
    task automatic verify_pkt(input string name, input logic [15:0] src, input logic [15:0] dst,
                              input logic [15:0] udp_len, input int nbeats,
                              input logic [3:0] last_keep, input int exp_err);
        logic [36:0] word;
        logic [36:0] exp;
        repeat (2) @(posedge ACLK);
        #1;
        check({name, " beat count"}, 64'(out_q.size()), 64'(2 + nbeats));
        for (int i = 0; i < 2 + nbeats; i++) begin
            if (out_q.size() > 0) begin
                word = out_q.pop_front();
                if (i == 0)      exp = {src, dst, 4'hF, 1'b0};
                else if (i == 1) exp = {udp_len, 16'h0000, 4'hF, 1'b0};
                else exp = {pdata(pkt_tag, i - 2), (i == nbeats + 1) ? last_keep : 4'hF, i == nbeats + 1};
                check($sformatf("%s word%0d", name, i), 64'(word), 64'(exp));
            end
        end
        out_q.delete();
        check({name, " len_err cycles"}, 64'(err_pulses), 64'(exp_err));
        err_pulses = 0;
        pkt_tag++;
    endtask

    initial begin
        int g;
        // Reset state
        #12;
        check("rst s_tready", 64'(s_axis_tready), 64'd0);
        check("rst m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst m_tlast",  64'(m_axis_tlast),  64'd0);
        check("rst m_tdata",  64'(m_axis_tdata),  64'd0);
        check("rst m_tkeep",  64'(m_axis_tkeep),  64'd0);
        check("rst len_err",  64'(len_err),       64'd0);
        check("rst busy",     64'(busy),          64'd0);
`ifdef OSPREYUDP_TX_STATS_EN
        check("rst pkt_count", 64'(pkt_count), 64'd0);
        check("rst err_count", 64'(err_count), 64'd0);
`endif
        @(negedge ACLK);
        ARESET = 1'b0;
        @(posedge ACLK);
        #1;

        // Disabled block ignores valid payload
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = pdata(pkt_tag, 0);
        s_axis_tkeep  = 4'hF;
        repeat (3) @(posedge ACLK);
        #1;
        check("disabled busy",    64'(busy),          64'd0);
        check("disabled m_valid", 64'(m_axis_tvalid), 64'd0);
        s_axis_tvalid = 1'b0;
        cfg_enable    = 1'b1;
        @(posedge ACLK);
        #1;

        // Test 1: 8-byte payload, plus first-beat latency
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = pdata(pkt_tag, 0);
        s_axis_tkeep  = 4'hF;
        s_axis_tlast  = 1'b0;
        @(negedge ACLK);
        check("lat idle m_valid", 64'(m_axis_tvalid), 64'd0);
        @(posedge ACLK);
        #1;
        check("lat hdr0 m_valid", 64'(m_axis_tvalid), 64'd1);
        check("lat hdr0 busy",    64'(busy),          64'd1);
        drive_pkt(2, 4'hF, 1'b0);
        verify_pkt("t1", 16'h1234, 16'h5678, 16'h0010, 2, 4'hF, 0);

        // Test 2: 10-byte config, partial final beat matches, full final beat mismatches
        cfg_payload_bytes = 16'd10;
        drive_pkt(3, 4'hC, 1'b0);
        verify_pkt("t2a", 16'h1234, 16'h5678, 16'h0012, 3, 4'hC, 0);
        drive_pkt(3, 4'hF, 1'b0);
        verify_pkt("t2b", 16'h1234, 16'h5678, 16'h0012, 3, 4'hF, 1);

        // Test 3: downstream ready toggling every cycle
        cfg_payload_bytes = 16'd8;
        stall_viol = 0;
        drive_pkt(2, 4'hF, 1'b1);
        verify_pkt("t3", 16'h1234, 16'h5678, 16'h0010, 2, 4'hF, 0);
        check("t3 stall stability", 64'(stall_viol), 64'd0);

        // Test 4: destination port changes after header 0
        cfg_payload_bytes = 16'd10;
        fork
            drive_pkt(3, 4'hC, 1'b0);
            begin
                g = 0;
                while (out_q.size() < 1 && g < 100) begin
                    @(posedge ACLK);
                    g++;
                end
                #1;
                cfg_dst_port = 16'hAAAA;
            end
        join
        verify_pkt("t4a", 16'h1234, 16'h5678, 16'h0012, 3, 4'hC, 0);
        drive_pkt(3, 4'hC, 1'b0);
        verify_pkt("t4b", 16'h1234, 16'hAAAA, 16'h0012, 3, 4'hC, 0);

        // Test 5: reset during payload beat 2
        cfg_payload_bytes = 16'd8;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = pdata(pkt_tag, 0);
        s_axis_tkeep  = 4'hF;
        s_axis_tlast  = 1'b0;
        g = 0;
        while (out_q.size() < 3 && g < 50) begin
            @(posedge ACLK);
            #1;
            g++;
        end
        check("t5 beats before reset", 64'(out_q.size()), 64'd3);
        s_axis_tdata = pdata(pkt_tag, 1);
        check("t5 pre-reset m_valid", 64'(m_axis_tvalid), 64'd1);
        ARESET = 1'b1;
        #1;
        check("t5 reset m_valid",  64'(m_axis_tvalid), 64'd0);
        check("t5 reset busy",     64'(busy),          64'd0);
        check("t5 reset s_tready", 64'(s_axis_tready), 64'd0);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        @(negedge ACLK);
        ARESET = 1'b0;
        out_q.delete();
        err_pulses = 0;
        pkt_tag++;
        @(posedge ACLK);
        #1;

        // Test 6: three packets after reset, the last one with a length mismatch
        drive_pkt(2, 4'hF, 1'b0);
        verify_pkt("t5 after reset", 16'h1234, 16'hAAAA, 16'h0010, 2, 4'hF, 0);
        drive_pkt(2, 4'hF, 1'b0);
        verify_pkt("t6 good", 16'h1234, 16'hAAAA, 16'h0010, 2, 4'hF, 0);
        drive_pkt(3, 4'hF, 1'b0);
        verify_pkt("t6 mismatch", 16'h1234, 16'hAAAA, 16'h0010, 3, 4'hF, 1);
`ifdef OSPREYUDP_TX_STATS_EN
        check("t6 pkt_count", 64'(pkt_count), 64'd3);
        check("t6 err_count", 64'(err_count), 64'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ospreyudp_tx_header_insert.md
Name: ospreyudp_tx_header_insert

Overview:
- Transmit-path stage directly downstream of the ospreyUDP AXI4-Lite register slave.
- Consumes the slave's configuration registers (src port, dst port, payload length) and a 32-bit AXI-Stream payload.
- Emits a UDP datagram stream with the 8-byte UDP header prepended.
- Checks the delivered payload length against the configured length.

Parameters:
- DATA_W, 32, stream data width in bits; only 32 is supported.
- KEEP_W, DATA_W/8, byte-enable width.

Ports:
- ACLK  in  1  clock
- ARESET  in  1  asynchronous reset, active-high
- cfg_src_port  in  16  UDP source port (register 0 [15:0])
- cfg_dst_port  in  16  UDP destination port (register 1 [15:0])
- cfg_payload_bytes  in  16  expected payload bytes (register 2 [15:0])
- cfg_enable  in  1  block enable (register 3 [0])
- s_axis_tdata  in  32  payload data
- s_axis_tkeep  in  4  payload byte enables, contiguous from MSB
- s_axis_tlast  in  1  last payload beat
- s_axis_tvalid  in  1  payload valid
- s_axis_tready  out  1  payload ready
- m_axis_tdata  out  32  datagram data
- m_axis_tkeep  out  4  datagram byte enables
- m_axis_tlast  out  1  last datagram beat
- m_axis_tvalid  out  1  datagram valid
- m_axis_tready  in  1  downstream ready
- len_err  out  1  one-cycle pulse on length mismatch
- busy  out  1  high when state is not IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE; s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0, len_err=0, busy=0; byte counter=0.
- IDLE:
  - s_axis_tready=0.
  - When cfg_enable=1 and s_axis_tvalid=1: latch src/dst/payload_bytes into shadow registers; compute udp_len = payload_bytes+8, modulo 2^16; go to HDR0.
- HDR0:
  - m_axis_tvalid=1, tdata={src,dst}, tkeep=4'hF, tlast=0.
  - On m_axis_tready, go to HDR1.
- HDR1:
  - tdata={udp_len,16'h0000}; checksum is always 0 (IPv4 permitted), tkeep=4'hF, tlast=0.
  - On m_axis_tready, go to PAYLOAD.
- PAYLOAD:
  - Combinational pass-through, zero added latency: m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready, and data/keep/last forwarded.
  - On each handshake, add popcount(tkeep) to the 17-bit byte counter.
  - On a handshake with tlast: compare counter+popcount against the latched payload_bytes.
  - If they differ, or payload_bytes>65527, pulse len_err on the following cycle.
  - Then clear the counter and go to IDLE.
- Total latency: first datagram beat appears 1 cycle after the triggering s_axis_tvalid. Per packet there are exactly 2 header beats, plus payload beats.
- Header beats are registered and held stable while m_axis_tready=0; AXIS rule: no tvalid drop before handshake.
- Config changes mid-packet are ignored; shadow values are used until IDLE.
- Dropping cfg_enable mid-packet does not abort; the packet completes and the next one is not started.
- A back-to-back packet requires one IDLE cycle between tlast and the next header.
- A payload beat with tkeep=0 is counted as 0 bytes and still forwarded.
- ARESET mid-packet:
  - Outputs return to reset values immediately.
  - The partial packet is lost.
  - Upstream must also be reset.

Optional Feature:
- Macro OSPREYUDP_TX_STATS_EN.
- When defined:
  - Adds outputs pkt_count[31:0] and err_count[15:0].
  - Both reset to 0.
  - pkt_count increments on each payload tlast handshake.
  - err_count increments with each len_err pulse and saturates at 16'hFFFF.
  - Both wrap/saturate independently of cfg_enable.
- When undefined: the ports and counters are absent; the core behaviour is identical.

Decomposition:
- Package ospreyudp_pkg holds:
  - state enum (IDLE, HDR0, HDR1, PAYLOAD)
  - UDP_HDR_BYTES=8, UDP_MAX_PAYLOAD=65527
  - register index constants (REG_SRC=0, REG_DST=1, REG_LEN=2, REG_CTRL=3)
- One sub-module: ospreyudp_popcount4, tkeep→byte count (0..4), purely combinational.

Test Plan:
1. src=0x1234, dst=0x5678, len=8, enable=1; 2 full payload beats, tlast on beat 2 → datagram words 0x12345678, 0x00100000, then payload; len_err=0.
2. Same config, len=10; 3 beats with final tkeep=4'hC → udp_len=0x0012, no len_err. Repeat with final tkeep=4'hF → len_err pulses once.
3. m_axis_tready toggles 0/1 every cycle across header and payload → header data stable while stalled, no beats lost or duplicated, 2+N output beats.
4. Change cfg_dst_port to 0xAAAA after HDR0 → second header word and the current packet unchanged; next packet header0 = {src,0xAAAA}.
5. Assert ARESET during PAYLOAD beat 2 → m_axis_tvalid=0, busy=0 in the same cycle; the following packet starts cleanly with HDR0.
6. With OSPREYUDP_TX_STATS_EN: 3 packets, one with a length mismatch → pkt_count=3, err_count=1.
